mcs4_timing_engine: RTL and testbench

- Parametrised successor to the separate clock-phase generator, timing generator and timing recovery blocks. One module produces the two-phase clk1/clk2 waveform and the 8-subcycle instruction timing (A1 A2 A3 M1 M2 X1 X2 X3) from sysclk.
- Operates as sync master, driving sync_out, or as sync slave, aligning to and supervising an external sync.
- Sits beside every CPU, ROM and RAM model in the MCS-4 system.

---
 rtl/mcs4_timing_engine.sv | 140 ++++++++++++++
 tb/tb_mcs4_timing_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_timing_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcs4_timing_engine                                                        |
// | Two-phase clk1/clk2 generator plus 8-subcycle MCS-4 instruction timing,   |
// | acting as sync master or as a supervising sync slave.                     |
// | Optional build macro: MCS4_SYNC_WATCHDOG_EN (slave sync-loss watchdog).   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mcs4_timing_engine #(
  parameter int MASTER      = 1,
  parameter int CLK1_TICKS  = 8,
  parameter int GAP12_TICKS = 4,
  parameter int CLK2_TICKS  = 8,
  parameter int GAP21_TICKS = 7,
  parameter int LOCK_COUNT  = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       sync_in,
  output logic       clk1,
  output logic       clk2,
  output logic [7:0] cycle,
  output logic       ph1_stb,
  output logic       ph2_stb,
  output logic       sync_out,
  output logic       locked,
  output logic       sync_err
);

  localparam int c_period = CLK1_TICKS + GAP12_TICKS + CLK2_TICKS + GAP21_TICKS;
  localparam int c_tick_w = $clog2(c_period);
  localparam int c_cnt_w  = $clog2(LOCK_COUNT + 1);

  localparam logic [c_tick_w-1:0] c_last_tick = c_tick_w'(c_period - 1);
  localparam logic [c_tick_w-1:0] c_clk1_end  = c_tick_w'(CLK1_TICKS);
  localparam logic [c_tick_w-1:0] c_ph1_tick  = c_tick_w'(CLK1_TICKS - 1);
  localparam logic [c_tick_w-1:0] c_clk2_beg  = c_tick_w'(CLK1_TICKS + GAP12_TICKS);
  localparam logic [c_tick_w-1:0] c_clk2_end  = c_tick_w'(CLK1_TICKS + GAP12_TICKS + CLK2_TICKS);
  localparam logic [c_tick_w-1:0] c_ph2_tick  = c_tick_w'(CLK1_TICKS + GAP12_TICKS + CLK2_TICKS - 1);
  localparam logic [c_cnt_w-1:0]  c_lock_cnt  = c_cnt_w'(LOCK_COUNT);
  localparam logic [7:0]          c_sub_a1    = 8'h01;
  localparam logic [7:0]          c_sub_x3    = 8'h80;

  logic                r_run;
  logic [c_tick_w-1:0] r_tick;
  logic [c_cnt_w-1:0]  r_good_cnt;

  logic                w_boundary;
  logic                w_start;
  logic [c_tick_w-1:0] w_next_tick;
  logic [7:0]          w_next_cycle;
  logic [c_cnt_w-1:0]  w_next_good;
  logic                w_next_locked;
  logic                w_err;

  // The first edge after reset opens A1 without counting as a sampled wrap.
  assign w_boundary = r_run && (r_tick == c_last_tick);
  assign w_start    = !r_run || w_boundary;

`ifdef MCS4_SYNC_WATCHDOG_EN
  logic [4:0] r_wd_cnt;
  logic [4:0] w_next_wd;
`endif

  always_comb begin
    w_next_tick   = w_start ? '0 : r_tick + 1'b1;
    w_next_cycle  = w_start ? {cycle[6:0], cycle[7]} : cycle;
    w_next_good   = r_good_cnt;
    w_next_locked = locked;
    w_err         = 1'b0;

    if (MASTER == 0 && w_boundary) begin
      if (sync_in && cycle == c_sub_x3) begin
        if (r_good_cnt < c_lock_cnt)
          w_next_good = r_good_cnt + 1'b1;
      end else if (sync_in || cycle == c_sub_x3) begin
        // Misplaced or missing sync: realign the subcycle only.
        w_next_cycle = c_sub_a1;
        w_next_good  = '0;
        w_err        = 1'b1;
      end
      w_next_locked = (w_next_good >= c_lock_cnt);
    end

`ifdef MCS4_SYNC_WATCHDOG_EN
    w_next_wd = r_wd_cnt;
    if (MASTER == 0 && w_boundary) begin
      if (sync_in) begin
        w_next_wd = '0;
      end else if (r_wd_cnt != 5'd16) begin
        w_next_wd = r_wd_cnt + 1'b1;
        if (r_wd_cnt == 5'd15) begin
          w_err         = 1'b1;
          w_next_good   = '0;
          w_next_locked = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_tick     <= '0;
      r_good_cnt <= '0;
      clk1       <= 1'b0;
      clk2       <= 1'b0;
      cycle      <= c_sub_x3;
      ph1_stb    <= 1'b0;
      ph2_stb    <= 1'b0;
      sync_out   <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= (MASTER != 0);
    end else begin
      r_run      <= 1'b1;
      r_tick     <= w_next_tick;
      r_good_cnt <= w_next_good;
      clk1       <= (w_next_tick < c_clk1_end);
      clk2       <= (w_next_tick >= c_clk2_beg) && (w_next_tick < c_clk2_end);
      cycle      <= w_next_cycle;
      ph1_stb    <= (w_next_tick == c_ph1_tick);
      ph2_stb    <= (w_next_tick == c_ph2_tick);
      sync_out   <= (MASTER != 0) && (w_next_cycle == c_sub_x3);
      sync_err   <= (MASTER == 0) && w_err;
      locked     <= (MASTER != 0) ? 1'b1 : w_next_locked;
    end
  end

`ifdef MCS4_SYNC_WATCHDOG_EN
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)
      r_wd_cnt <= '0;
    else
      r_wd_cnt <= w_next_wd;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcs4_timing_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mcs4_timing_engine                                                     |
// | Master and slave engines side by side against an arithmetic timing model. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mcs4_timing_engine;

  logic sysclk = 1'b0;
  logic rst_n = 1'b0;
  logic use_master = 1'b1;
  logic tb_sync = 1'b0;
  logic s_sync_in;

  logic m_clk1, m_clk2, m_ph1, m_ph2, m_so, m_locked, m_err;
  logic s_clk1, s_clk2, s_ph1, s_ph2, s_so, s_locked, s_err;
  logic [7:0] m_cycle, s_cycle;

  assign s_sync_in = use_master ? m_so : tb_sync;

  always #5 sysclk = ~sysclk;

  mcs4_timing_engine #(.MASTER(1)) u_master (
    .sysclk(sysclk), .rst_n(rst_n), .sync_in(tb_sync),
    .clk1(m_clk1), .clk2(m_clk2), .cycle(m_cycle), .ph1_stb(m_ph1), .ph2_stb(m_ph2),
    .sync_out(m_so), .locked(m_locked), .sync_err(m_err)
  );

  mcs4_timing_engine #(.MASTER(0)) u_slave (
    .sysclk(sysclk), .rst_n(rst_n), .sync_in(s_sync_in),
    .clk1(s_clk1), .clk2(s_clk2), .cycle(s_cycle), .ph1_stb(s_ph1), .ph2_stb(s_ph2),
    .sync_out(s_so), .locked(s_locked), .sync_err(s_err)
  );

  typedef struct packed {
    logic       c1;
    logic       c2;
    logic [7:0] cyc;
    logic       p1;
    logic       p2;
    logic       so;
  } exp_t;

  typedef struct {
    int         k;
    logic [7:0] cyc;
    logic       c1, c2, p1, p2, so, sl;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[14];
  int   checks = 0;
  int   failures = 0;
  int   k = 0;
  logic slv_chk = 1'b1;

  // Edge n (1-based after reset release) sits at tick (n-1)%27 of subcycle ((n-1)/27)%8.
  function automatic exp_t model(int n);
    exp_t e;
    int   t, s;
    t     = (n - 1) % 27;
    s     = ((n - 1) / 27) % 8;
    e.c1  = (t < 8);
    e.c2  = (t >= 12) && (t < 20);
    e.cyc = 8'd1 << s;
    e.p1  = (t == 7);
    e.p2  = (t == 19);
    e.so  = (s == 7);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, k);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge sysclk);
    k++;
    sbq.push_back(model(k));
    #1;
    e = sbq.pop_front();
    chk("m_clk1", m_clk1, e.c1);
    chk("m_clk2", m_clk2, e.c2);
    chk("m_cycle", m_cycle, e.cyc);
    chk("m_ph1", m_ph1, e.p1);
    chk("m_ph2", m_ph2, e.p2);
    chk("m_sync_out", m_so, e.so);
    chk("m_overlap", m_clk1 & m_clk2, 0);
    chk("m_locked", m_locked, 1);
    chk("m_sync_err", m_err, 0);
    chk("s_clk1", s_clk1, e.c1);
    chk("s_clk2", s_clk2, e.c2);
    chk("s_sync_out", s_so, 0);
    if (slv_chk) begin
      chk("s_cycle", s_cycle, e.cyc);
      chk("s_sync_err", s_err, 0);
      chk("s_locked", s_locked, k >= 433);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_m_clk1"}, m_clk1, 0);
    chk({tag, "_m_clk2"}, m_clk2, 0);
    chk({tag, "_m_cycle"}, m_cycle, 8'h80);
    chk({tag, "_m_ph"}, {m_ph1, m_ph2}, 0);
    chk({tag, "_m_sync_out"}, m_so, 0);
    chk({tag, "_m_sync_err"}, m_err, 0);
    chk({tag, "_m_locked"}, m_locked, 1);
    chk({tag, "_s_clk"}, {s_clk1, s_clk2}, 0);
    chk({tag, "_s_cycle"}, s_cycle, 8'h80);
    chk({tag, "_s_ph"}, {s_ph1, s_ph2}, 0);
    chk({tag, "_s_sync_err"}, s_err, 0);
    chk({tag, "_s_locked"}, s_locked, 0);
  endtask

  initial begin
    tbl[0]  = '{1,   8'h01, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{8,   8'h01, 1, 0, 1, 0, 0, 0};
    tbl[2]  = '{9,   8'h01, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{12,  8'h01, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{13,  8'h01, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{20,  8'h01, 0, 1, 0, 1, 0, 0};
    tbl[6]  = '{21,  8'h01, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{27,  8'h01, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{28,  8'h02, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{190, 8'h80, 1, 0, 0, 0, 1, 0};
    tbl[10] = '{216, 8'h80, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{217, 8'h01, 1, 0, 0, 0, 0, 0};
    tbl[12] = '{432, 8'h80, 0, 0, 0, 0, 1, 0};
    tbl[13] = '{433, 8'h01, 1, 0, 0, 0, 0, 1};

    repeat (3) @(negedge sysclk);
    chk_reset("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      while (k < tbl[i].k) step();
      chk("v_cycle", m_cycle, tbl[i].cyc);
      chk("v_clk1", m_clk1, tbl[i].c1);
      chk("v_clk2", m_clk2, tbl[i].c2);
      chk("v_ph1", m_ph1, tbl[i].p1);
      chk("v_ph2", m_ph2, tbl[i].p2);
      chk("v_sync_out", m_so, tbl[i].so);
      chk("v_s_locked", s_locked, tbl[i].sl);
    end

    // Misplaced sync at the boundary leaving M1.
    slv_chk    = 1'b0;
    use_master = 1'b0;
    tb_sync    = 1'b0;
    while (k < 540) step();
    chk("mis_pre_cycle", s_cycle, 8'h08);
    chk("mis_pre_locked", s_locked, 1);
    tb_sync = 1'b1;
    step();
    tb_sync = 1'b0;
    chk("mis_s_cycle", s_cycle, 8'h01);
    chk("mis_s_err", s_err, 1);
    chk("mis_s_locked", s_locked, 0);
    chk("mis_m_cycle", m_cycle, 8'h10);
    step();
    chk("mis_err_pulse", s_err, 0);
    chk("mis_post_cycle", s_cycle, 8'h01);

    // Two good syncs on the slave's new X3 boundaries.
    while (k < 756) step();
    chk("rl1_pre_cycle", s_cycle, 8'h80);
    tb_sync = 1'b1;
    step();
    tb_sync = 1'b0;
    chk("rl1_cycle", s_cycle, 8'h01);
    chk("rl1_err", s_err, 0);
    chk("rl1_locked", s_locked, 0);
    while (k < 972) step();
    tb_sync = 1'b1;
    step();
    tb_sync = 1'b0;
    chk("rl2_locked", s_locked, 1);
    chk("rl2_err", s_err, 0);
    chk("rl2_cycle", s_cycle, 8'h01);

    // Missed sync at the next X3 boundary.
    while (k < 1188) step();
    chk("miss_pre_err", s_err, 0);
    chk("miss_pre_cycle", s_cycle, 8'h80);
    chk("miss_pre_locked", s_locked, 1);
    step();
    chk("miss_err", s_err, 1);
    chk("miss_locked", s_locked, 0);
    chk("miss_cycle", s_cycle, 8'h01);
    step();
    chk("miss_err_pulse", s_err, 0);

    // Asynchronous reset between clock edges.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");

    @(negedge sysclk);
    k = 0;
    sbq.delete();
    use_master = 1'b1;
    slv_chk    = 1'b1;
    rst_n      = 1'b1;
    while (k < 30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
